// File: rtl/hng_pkg.sv
// Shared definitions for the HNG uncompute datapath.
// Holds the default counter width and lane-parallel forward/inverse HNG
// functions. The functions work on a fixed maximum lane width; callers
// zero-extend narrower vectors and take the low bits of each result field.
package hng_pkg;

    localparam int HNG_CNT_W = 16;
    localparam int HNG_MAX_W = 64;

    typedef logic [HNG_MAX_W-1:0] hng_lane_t;

    // Four lane vectors. hng_fwd fills it with {P,Q,R,S}; hng_inv with {A,B,C,D}.
    typedef struct packed {
        hng_lane_t v0;
        hng_lane_t v1;
        hng_lane_t v2;
        hng_lane_t v3;
    } hng_quad_t;

    // Inverse gate: recovers {A,B,C,D} from {P,Q,R,S}.
    function automatic hng_quad_t hng_inv(hng_lane_t p, hng_lane_t q,
                                          hng_lane_t r, hng_lane_t s);
        hng_quad_t o;
        o.v0 = p;
        o.v1 = q;
        o.v2 = r ^ p ^ q;
        o.v3 = s ^ ((p ^ q) & o.v2) ^ (p & q);
        return o;
    endfunction

    // Forward gate: produces {P,Q,R,S} from {A,B,C,D}.
    function automatic hng_quad_t hng_fwd(hng_lane_t a, hng_lane_t b,
                                          hng_lane_t c, hng_lane_t d);
        hng_quad_t o;
        o.v0 = a;
        o.v1 = b;
        o.v2 = a ^ b ^ c;
        o.v3 = ((a ^ b) & c) ^ (a & b) ^ d;
        return o;
    endfunction

endpackage

// File: rtl/hng_pipe_stage.sv
// Generic valid/ready register slice. Accepts when empty or when the
// downstream side takes the held word in the same cycle. Data is only
// written when a word actually moves in, so idle cycles leave it untouched.
module hng_pipe_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data
);

    logic advance;

    assign advance  = !dn_valid || dn_ready;
    assign up_ready = advance;

    // Slice register: valid follows upstream on advance, data loads only with a word.
    always_ff @(posedge clk) begin
        if (rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (advance) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/hng_uncompute_pipe.sv
// Streaming HNG uncompute: {P,Q,R,S} in, recovered {A,B,C,D} out, two
// register stages, W lanes in parallel, with a saturating delivered-word
// counter. in_ready is combinational from out_ready through both slices.
// Optional ancilla check enabled by macro ANCILLA_CHECK_EN: flags lanes where
// recovered C is not 1 or D is not 0, and counts output words with any flag.
module hng_uncompute_pipe
    import hng_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = HNG_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_p,
    input  logic [W-1:0]     in_q,
    input  logic [W-1:0]     in_r,
    input  logic [W-1:0]     in_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_a,
    output logic [W-1:0]     out_b,
    output logic [W-1:0]     out_c,
    output logic [W-1:0]     out_d,
    output logic [CNT_W-1:0] word_count,
    input  logic             clr_stats
`ifdef ANCILLA_CHECK_EN
    ,
    output logic [W-1:0]     out_anc_err,
    output logic [CNT_W-1:0] err_count
`endif
);

    localparam int S1_W = 5 * W;
`ifdef ANCILLA_CHECK_EN
    localparam int S2_W = 5 * W;
`else
    localparam int S2_W = 4 * W;
`endif

    logic [W-1:0]    x_in;
    logic [W-1:0]    c_in;
    logic [S1_W-1:0] s1_in_data;
    logic [S1_W-1:0] s1_data;
    logic            s1_valid;
    logic            s2_ready;

    logic [W-1:0]    s1_p;
    logic [W-1:0]    s1_q;
    logic [W-1:0]    s1_x;
    logic [W-1:0]    s1_c;
    logic [W-1:0]    s1_s;
    logic [W-1:0]    d_calc;
    logic [S2_W-1:0] s2_in_data;
    logic [S2_W-1:0] s2_data;
    logic            out_xfer;

    // Stage 1 precompute: shared x = P^Q and recovered C.
    assign x_in       = in_p ^ in_q;
    assign c_in       = in_r ^ x_in;
    assign s1_in_data = {in_p, in_q, x_in, c_in, in_s};

    hng_pipe_stage #(.DW(S1_W)) u_s1 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (in_valid),
        .up_ready (in_ready),
        .up_data  (s1_in_data),
        .dn_valid (s1_valid),
        .dn_ready (s2_ready),
        .dn_data  (s1_data)
    );

    assign s1_p = s1_data[5*W-1:4*W];
    assign s1_q = s1_data[4*W-1:3*W];
    assign s1_x = s1_data[3*W-1:2*W];
    assign s1_c = s1_data[2*W-1:1*W];
    assign s1_s = s1_data[1*W-1:0];

    // Stage 2 precompute: recovered D from the stage-1 terms.
    assign d_calc = s1_s ^ (s1_x & s1_c) ^ (s1_p & s1_q);

`ifdef ANCILLA_CHECK_EN
    // Lane error when the ancilla pair deviates from C=1, D=0.
    assign s2_in_data = {s1_p, s1_q, s1_c, d_calc, (~s1_c) | d_calc};
`else
    assign s2_in_data = {s1_p, s1_q, s1_c, d_calc};
`endif

    hng_pipe_stage #(.DW(S2_W)) u_s2 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (s1_valid),
        .up_ready (s2_ready),
        .up_data  (s2_in_data),
        .dn_valid (out_valid),
        .dn_ready (out_ready),
        .dn_data  (s2_data)
    );

    assign out_a = s2_data[S2_W-1:S2_W-W];
    assign out_b = s2_data[S2_W-W-1:S2_W-2*W];
    assign out_c = s2_data[S2_W-2*W-1:S2_W-3*W];
    assign out_d = s2_data[S2_W-3*W-1:S2_W-4*W];

    assign out_xfer = out_valid && out_ready;

    // Delivered-word counter: saturating, clear takes priority over a transfer.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            word_count <= '0;
        end else if (out_xfer && (word_count != {CNT_W{1'b1}})) begin
            word_count <= word_count + CNT_W'(1);
        end
    end

`ifdef ANCILLA_CHECK_EN
    assign out_anc_err = s2_data[W-1:0];

    // Ancilla error counter: counts delivered words with any lane flagged.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            err_count <= '0;
        end else if (out_xfer && (|out_anc_err) && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hng_uncompute_pipe.sv
module tb_hng_uncompute_pipe;
    import hng_pkg::*;

    localparam int W     = 8;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_p, in_q, in_r, in_s;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_a, out_b, out_c, out_d;
    logic [CNT_W-1:0] word_count;
    logic             clr_stats;
`ifdef ANCILLA_CHECK_EN
    logic [W-1:0]     out_anc_err;
    logic [CNT_W-1:0] err_count;
`endif

    always #5 clk = ~clk;

    hng_uncompute_pipe #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_p       (in_p),
        .in_q       (in_q),
        .in_r       (in_r),
        .in_s       (in_s),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_c      (out_c),
        .out_d      (out_d),
        .word_count (word_count),
        .clr_stats  (clr_stats)
`ifdef ANCILLA_CHECK_EN
        ,
        .out_anc_err(out_anc_err),
        .err_count  (err_count)
`endif
    );

    int checks   = 0;
    int failures = 0;

    vec_t        exp_q[$];
    vec_t        cur;
    logic [15:0] wc_m = '0;
    logic [15:0] ec_m = '0;
    logic        stalled_prev = 1'b0;
    logic        last_in_fire = 1'b0;
    int          out_fires = 0;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic vec_t rand_vec();
        return vec_t'($urandom());
    endfunction

    task automatic drive(vec_t v);
        hng_quad_t f;
        f = hng_fwd(64'(v.a), 64'(v.b), 64'(v.c), 64'(v.d));
        cur      = v;
        in_p     = f.v0[7:0];
        in_q     = f.v1[7:0];
        in_r     = f.v2[7:0];
        in_s     = f.v3[7:0];
        in_valid = 1'b1;
    endtask

    // One clock: check the visible output against the scoreboard front,
    // then update the model with what moved on this edge.
    task automatic tick();
        logic inf, outf;
        vec_t it;
        #1;
        inf  = in_valid && in_ready;
        outf = out_valid && out_ready;
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    it = exp_q[0];
                    check_eq("out_a", 32'(out_a), 32'(it.a));
                    check_eq("out_b", 32'(out_b), 32'(it.b));
                    check_eq("out_c", 32'(out_c), 32'(it.c));
                    check_eq("out_d", 32'(out_d), 32'(it.d));
`ifdef ANCILLA_CHECK_EN
                    check_eq("anc_err", 32'(out_anc_err), 32'((~it.c) | it.d));
`endif
                end
            end
            if (stalled_prev) check_eq("valid_hold", 32'(out_valid), 32'd1);
            stalled_prev = out_valid && !out_ready;
        end
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            wc_m = '0;
            ec_m = '0;
            stalled_prev = 1'b0;
            last_in_fire = 1'b0;
        end else begin
            if (outf && exp_q.size() != 0) begin
                it = exp_q.pop_front();
                out_fires++;
                if (wc_m != 16'hFFFF) wc_m = wc_m + 16'd1;
                if ((((~it.c) | it.d) != 8'h00) && ec_m != 16'hFFFF) ec_m = ec_m + 16'd1;
            end
            if (inf) exp_q.push_back(cur);
            if (clr_stats) begin
                wc_m = '0;
                ec_m = '0;
            end
            last_in_fire = inf;
        end
        @(negedge clk);
        check_eq("word_count", 32'(word_count), 32'(wc_m));
`ifdef ANCILLA_CHECK_EN
        check_eq("err_count", 32'(err_count), 32'(ec_m));
`endif
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int stalls, fires_start, acc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
        in_p = '0; in_q = '0; in_r = '0; in_s = '0; cur = '0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_word_count", 32'(word_count), 32'd0);
        check_eq("rst_outs", {out_a, out_b, out_c, out_d}, 32'd0);

        // Directed vector, latency exactly 2.
        out_ready = 1'b1;
        drive('{a: 8'hA5, b: 8'h3C, c: 8'hFF, d: 8'h00});
        check_eq("dir_p", {in_p, in_q, in_r, in_s}, 32'hA53C66BD);
        tick();
        in_valid = 1'b0;
        #1 check_eq("lat1_valid", 32'(out_valid), 32'd0);
        tick();
        #1;
        check_eq("lat2_valid", 32'(out_valid), 32'd1);
        check_eq("dir_out", {out_a, out_b, out_c, out_d}, 32'hA53CFF00);
        tick();
        check_eq("dir_count", 32'(word_count), 32'd1);

        // Full-throughput random stream.
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        stalls = 0;
        fires_start = out_fires;
        for (int i = 0; i < 1000; i++) begin
            drive(rand_vec());
            #1;
            if (!in_ready) stalls++;
            tick();
        end
        check_eq("stream_fires", 32'(out_fires - fires_start), 32'd998);
        in_valid = 1'b0;
        tick();
        tick();
        check_eq("stream_stalls", 32'(stalls), 32'd0);
        check_eq("stream_count", 32'(word_count), 32'd1000);
        check_eq("stream_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: 5 stalled cycles fill exactly two slots.
        out_ready = 1'b0;
        acc = 0;
        drive(rand_vec());
        for (int i = 0; i < 5; i++) begin
            tick();
            if (last_in_fire) begin
                acc++;
                drive(rand_vec());
            end
        end
        #1;
        check_eq("stall_in_ready", 32'(in_ready), 32'd0);
        check_eq("stall_accepted", 32'(acc), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (last_in_fire) drive(rand_vec());
        end
        drain();

        // Clear coinciding with an output transfer.
        drive(rand_vec());
        tick();
        drive(rand_vec());
        tick();
        in_valid  = 1'b0;
        clr_stats = 1'b1;
        #1 check_eq("clr_setup_valid", 32'(out_valid), 32'd1);
        tick();
        clr_stats = 1'b0;
        check_eq("clr_wins", 32'(word_count), 32'd0);
        drain();

`ifdef ANCILLA_CHECK_EN
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        drive('{a: 8'h12, b: 8'h34, c: 8'hFF, d: 8'h01});
        tick();
        in_valid = 1'b0;
        tick();
        #1 check_eq("anc_err_dir", 32'(out_anc_err), 32'h01);
        tick();
        check_eq("anc_err_count", 32'(err_count), 32'd1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check_eq("anc_clr_words", 32'(word_count), 32'd0);
        check_eq("anc_clr_errs", 32'(err_count), 32'd0);
`endif

        // Random valid/ready with occasional clears.
        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || last_in_fire) begin
                if ($urandom_range(0, 3) != 0) drive(rand_vec());
                else in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            clr_stats = ($urandom_range(0, 30) == 0);
            tick();
        end
        clr_stats = 1'b0;
        drain();

        // Reset with two vectors in flight.
        out_ready = 1'b0;
        drive(rand_vec());
        tick();
        drive(rand_vec());
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("mrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("mrst_word_count", 32'(word_count), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(rand_vec());
            tick();
        end
        drain();
        check_eq("final_count", 32'(word_count), 32'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
